des_fp_tx: RTL

//  Output end of the DES datapath: inverse of the input-side initial permutation (IP).

---
 rtl/des_fp_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/des_fp_tx.sv
// des_fp_tx: output end of the DES datapath.
// Takes the round-16 block {L16,R16}, optionally swaps the halves to {R16,L16}, and applies the
// final permutation FP = IP^-1. The permuted block is streamed out in OUT_W-bit beats from a
// shift register backed by a hold register, so blocks can follow each other without bubbles.
//
// Ports:
//   i_Clk    clock, all state on the rising edge
//   i_Rst    synchronous reset, active-high
//   i_Valid  i_Data carries a round-16 block
//   o_Ready  block accepted on the edge where i_Valid & o_Ready (low only while HOLD is full)
//   i_Data   {L16[63:32], R16[31:0]}
//   o_Valid  o_Data carries a valid beat
//   i_Ready  downstream takes the beat on the edge where o_Valid & i_Ready
//   o_Data   current beat, zero while o_Valid is low
//   o_Last   current beat is the final beat of its block
//   o_Busy   shift or hold register occupied
module des_fp_tx #(
  parameter int unsigned OUT_W   = 8,  // 8, 16, 32 or 64
  parameter int unsigned SWAP_EN = 1,  // 1: swap halves before FP
  parameter int unsigned MSB_1ST = 1   // 1: first beat is the top OUT_W bits
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [63:0]      i_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [OUT_W-1:0] o_Data,
  output logic             o_Last,
  output logic             o_Busy
);

  localparam int unsigned BEATS = 64 / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // StIdle: both empty; StSend: shift full, hold empty; StStall: both full.
  typedef enum logic [1:0] {StIdle, StSend, StStall} state_e;

  state_e           state_q, state_d;
  logic [63:0]      shift_q, shift_d;
  logic [63:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // FP in DES 1-indexed terms: output bit k takes pre-output bit FPtab[k], with DES bit n living
  // at vector bit 64-n. The table is regular: in row r, column c (both 0-based) the source is
  // 40+4c-r for even c and 4c+4-r for odd c.
  function automatic logic [63:0] final_perm(input logic [63:0] p);
    logic [63:0] o;
    int unsigned r, c, src;
    o = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      r   = k / 8;
      c   = k % 8;
      src = ((c % 2) == 0) ? (40 + 4 * c - r) : (4 * c + 4 - r);
      o[6'(63 - k)] = p[6'(64 - src)];
    end
    return o;
  endfunction

  logic [63:0] pre_fp;
  logic [63:0] perm;
  logic [63:0] shifted;
  logic        accept;
  logic        beat_hs;
  logic        last_hs;

  assign pre_fp  = (SWAP_EN != 0) ? {i_Data[31:0], i_Data[63:32]} : i_Data;
  assign perm    = final_perm(pre_fp);
  // Move the next beat to whichever end the output taps.
  assign shifted = (MSB_1ST != 0) ? (shift_q << OUT_W) : (shift_q >> OUT_W);

  assign o_Valid = (state_q != StIdle);
  assign o_Ready = (state_q != StStall);
  assign o_Busy  = (state_q != StIdle);
  assign o_Last  = o_Valid & (cnt_q == LAST_CNT);
  assign o_Data  = !o_Valid ? '0 :
                   (MSB_1ST != 0) ? shift_q[63 -: OUT_W] : shift_q[OUT_W-1:0];

  assign accept  = i_Valid & o_Ready;
  assign beat_hs = o_Valid & i_Ready;
  assign last_hs = beat_hs & o_Last;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = perm;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (last_hs) begin
          // Shift drains this edge; a new block goes straight into it.
          cnt_d = '0;
          if (accept) begin
            shift_d = perm;
          end else begin
            shift_d = '0;
            state_d = StIdle;
          end
        end else begin
          if (beat_hs) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
          if (accept) begin
            hold_d  = perm;
            state_d = StStall;
          end
        end
      end
      StStall: begin
        // o_Ready is low here, so no accept can coincide with the hold-to-shift move.
        if (last_hs) begin
          shift_d = hold_q;
          hold_d  = '0;
          cnt_d   = '0;
          state_d = StSend;
        end else if (beat_hs) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        shift_d = '0;
        hold_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
